mdio_peripheral: RTL and testbench

//   PHY-side MDIO target. Sits directly downstream of mdio_controller. Consumes MDC/MDIO_OUT/MDIO_OE,

---
 rtl/mdio_peripheral.sv | 172 +++++++++++++++++
 tb/tb_mdio_peripheral.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_peripheral.sv
// PHY-side MDIO target: decodes controller frames, strobes register writes,
// and serialises register reads back to the controller on MDIO_IN.
module mdio_peripheral #(
    parameter logic [4:0] PHY_ADDR = 5'd1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MDC,
    input  logic        MDIO_OUT,
    input  logic        MDIO_OE,
    output logic        MDIO_IN,
    output logic        PHY_OE,
    output logic [4:0]  ADDR,
    output logic [15:0] WR_DATA,
    output logic        WR_STB,
    output logic        RD_STB,
    input  logic [15:0] RD_DATA,
    output logic        FRAME_ERR
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_WR,
        S_RD,
        S_SKIP
    } state_t;

    state_t      state;
    logic        mdc_q;
    logic        rise;
    logic        fall;
    logic [4:0]  cnt;       // index of the next bit to be sampled
    logic [12:0] hdr;       // header bits 0..12; bit 13 is taken live at decode
    logic [13:0] hdr_full;
    logic [14:0] wr_sr;     // data bits ahead of the final one
    logic [15:0] tx;
    logic        rd_pend;

    // MDC edge detection and the complete header as seen on the bit-13 rise
    always_comb begin
        rise     = MDC & ~mdc_q;
        fall     = ~MDC & mdc_q;
        hdr_full = {hdr, MDIO_OUT};
    end

    // Frame FSM with registered outputs
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state     <= S_IDLE;
            mdc_q     <= 1'b0;
            cnt       <= '0;
            hdr       <= '0;
            wr_sr     <= '0;
            tx        <= '0;
            rd_pend   <= 1'b0;
            MDIO_IN   <= 1'b0;
            PHY_OE    <= 1'b0;
            ADDR      <= '0;
            WR_DATA   <= '0;
            WR_STB    <= 1'b0;
            RD_STB    <= 1'b0;
            FRAME_ERR <= 1'b0;
        end else begin
            mdc_q     <= MDC;
            WR_STB    <= 1'b0;
            RD_STB    <= 1'b0;
            FRAME_ERR <= 1'b0;
            // register contents are valid the CLK after RD_STB
            rd_pend   <= RD_STB;
            if (rd_pend)
                tx <= RD_DATA;

            case (state)
                S_IDLE: begin
                    if (rise && MDIO_OE) begin
                        hdr   <= {12'd0, MDIO_OUT};
                        cnt   <= 5'd1;
                        state <= S_HDR;
                    end
                end

                S_HDR: begin
                    if (rise) begin
                        if (!MDIO_OE) begin
                            cnt   <= '0;
                            state <= S_IDLE;
                        end else begin
                            cnt <= cnt + 5'd1;
                            hdr <= {hdr[11:0], MDIO_OUT};
                            if (cnt == 5'd13) begin
                                if (hdr_full[9:5] != PHY_ADDR) begin
                                    state <= S_SKIP;
                                end else if (hdr_full[13:12] != 2'b01 ||
                                             !(hdr_full[11:10] == 2'b01 || hdr_full[11:10] == 2'b10)) begin
                                    FRAME_ERR <= 1'b1;
                                    state     <= S_SKIP;
                                end else if (hdr_full[11:10] == 2'b01) begin
                                    ADDR  <= hdr_full[4:0];
                                    state <= S_WR;
                                end else begin
                                    ADDR   <= hdr_full[4:0];
                                    RD_STB <= 1'b1;
                                    state  <= S_RD;
                                end
                            end
                        end
                    end
                end

                S_WR: begin
                    if (rise) begin
                        if (!MDIO_OE) begin
                            cnt   <= '0;
                            state <= S_IDLE;
                        end else begin
                            cnt <= cnt + 5'd1;
                            if (cnt >= 5'd16)
                                wr_sr <= {wr_sr[13:0], MDIO_OUT};
                            // WR_DATA is only committed on a complete frame
                            if (cnt == 5'd31) begin
                                WR_DATA <= {wr_sr, MDIO_OUT};
                                WR_STB  <= 1'b1;
                                cnt     <= '0;
                                state   <= S_IDLE;
                            end
                        end
                    end
                end

                S_RD: begin
                    if (rise) begin
                        cnt <= cnt + 5'd1;
                        // controller driving while we drive: release and ride out the frame
                        if (MDIO_OE && PHY_OE) begin
                            PHY_OE  <= 1'b0;
                            MDIO_IN <= 1'b0;
                            state   <= (cnt == 5'd31) ? S_IDLE : S_SKIP;
                        end
                    end else if (fall) begin
                        if (cnt == 5'd15) begin
                            PHY_OE  <= 1'b1;
                            MDIO_IN <= 1'b0;
                        end else if (cnt == 5'd0) begin
                            // counter wrapped: bit 31 has been sampled
                            PHY_OE  <= 1'b0;
                            MDIO_IN <= 1'b0;
                            state   <= S_IDLE;
                        end else if (cnt >= 5'd16) begin
                            MDIO_IN <= tx[15];
                            tx      <= {tx[14:0], 1'b0};
                        end
                    end
                end

                S_SKIP: begin
                    if (rise) begin
                        if (cnt == 5'd31) begin
                            cnt   <= '0;
                            state <= S_IDLE;
                        end else begin
                            cnt <= cnt + 5'd1;
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdio_peripheral.sv
// Directed bench for mdio_peripheral: drives MDIO frames at MDC=CLK/2 and
// checks every output every CLK against a bit-index model of the frame.
module tb_mdio_peripheral;

    localparam logic [4:0] PHY = 5'd1;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        MDC;
    logic        MDIO_OUT;
    logic        MDIO_OE;
    logic        MDIO_IN;
    logic        PHY_OE;
    logic [4:0]  ADDR;
    logic [15:0] WR_DATA;
    logic        WR_STB;
    logic        RD_STB;
    logic [15:0] RD_DATA;
    logic        FRAME_ERR;

    int vectors = 0;
    int errors  = 0;

    // expected outputs for the current CLK
    logic        e_wr, e_rd, e_fe, e_oe, e_in;
    logic [4:0]  m_addr;
    logic [15:0] m_wrd;
    logic        phase_low;
    logic        chk_en;

    // observation counters
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    int          fe_cnt = 0;
    int          oe_cyc = 0;
    logic [16:0] rx;

    mdio_peripheral #(.PHY_ADDR(PHY)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .MDC       (MDC),
        .MDIO_OUT  (MDIO_OUT),
        .MDIO_OE   (MDIO_OE),
        .MDIO_IN   (MDIO_IN),
        .PHY_OE    (PHY_OE),
        .ADDR      (ADDR),
        .WR_DATA   (WR_DATA),
        .WR_STB    (WR_STB),
        .RD_STB    (RD_STB),
        .RD_DATA   (RD_DATA),
        .FRAME_ERR (FRAME_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // value on MDIO_IN after the fall that follows the rise of bit b of a read
    function automatic logic fall_val(input logic [15:0] d, input int b);
        if (b >= 15 && b <= 30)
            return d[30-b];
        return 1'b0;
    endfunction

    task automatic set_idle_exp();
        e_wr = 1'b0; e_rd = 1'b0; e_fe = 1'b0; e_oe = 1'b0; e_in = 1'b0;
    endtask

    // compare process: every CLK, 2 time units after the active edge
    initial begin
        forever begin
            @(posedge CLK);
            #2;
            if (chk_en) begin
                chk("WR_STB",    32'(WR_STB),    32'(e_wr));
                chk("RD_STB",    32'(RD_STB),    32'(e_rd));
                chk("FRAME_ERR", 32'(FRAME_ERR), 32'(e_fe));
                chk("PHY_OE",    32'(PHY_OE),    32'(e_oe));
                chk("MDIO_IN",   32'(MDIO_IN),   32'(e_in));
                chk("ADDR",      32'(ADDR),      32'(m_addr));
                chk("WR_DATA",   32'(WR_DATA),   32'(m_wrd));
                if (WR_STB)    wr_cnt++;
                if (RD_STB)    rd_cnt++;
                if (FRAME_ERR) fe_cnt++;
                if (PHY_OE)    oe_cyc++;
                if (phase_low && PHY_OE)
                    rx = {rx[15:0], MDIO_IN};
            end
        end
    end

    task automatic drive_idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            MDC = 1'b1; MDIO_OE = 1'b0; MDIO_OUT = 1'b0; phase_low = 1'b0;
            set_idle_exp();
            @(negedge CLK);
            MDC = 1'b0; phase_low = 1'b1;
        end
    endtask

    // One 32-bit frame. OE is dropped from bit drop_at onward (writes);
    // reads release the bus from bit 14. rst_at >= 0 pulses RESET in the
    // low phase of that bit.
    task automatic drive_frame(input logic [1:0] st, input logic [1:0] op,
                               input logic [4:0] phy, input logic [4:0] regad,
                               input logic [15:0] data, input int drop_at, input int rst_at);
        logic [31:0] bits;
        logic addressed, good, is_wr, is_rd, bad, oe, dead;
        bits      = {st, op, phy, regad, 2'b10, data};
        addressed = (phy == PHY);
        good      = addressed && st == 2'b01 && (op == 2'b01 || op == 2'b10);
        is_wr     = good && op == 2'b01;
        is_rd     = good && op == 2'b10;
        bad       = addressed && !good;
        dead      = 1'b0;
        for (int k = 0; k < 32; k++) begin
            oe = (op == 2'b10) ? (k < 14) : (k < drop_at);
            @(negedge CLK);
            if (dead && k == rst_at + 2)
                RESET = 1'b1;
            MDC = 1'b1; MDIO_OE = oe; MDIO_OUT = oe ? bits[31-k] : 1'b0; phase_low = 1'b0;
            if (dead) begin
                set_idle_exp();
            end else begin
                e_wr = is_wr && k == 31 && drop_at > 31;
                e_rd = is_rd && k == 13;
                e_fe = bad && k == 13;
                e_oe = is_rd && k >= 15;
                e_in = (is_rd && k >= 1) ? fall_val(RD_DATA, k - 1) : 1'b0;
                if (good && k == 13 && drop_at > 13)
                    m_addr = regad;
                if (e_wr)
                    m_wrd = data;
            end
            @(negedge CLK);
            MDC = 1'b0; phase_low = 1'b1;
            e_wr = 1'b0; e_rd = 1'b0; e_fe = 1'b0;
            if (!dead) begin
                e_oe = is_rd && k >= 14 && k <= 30;
                e_in = is_rd ? fall_val(RD_DATA, k) : 1'b0;
            end
            if (k == rst_at) begin
                #2;
                dead = 1'b1;
                set_idle_exp();
                m_addr = '0;
                m_wrd  = '0;
                RESET  = 1'b0;
                #1;
                chk("rst_async_PHY_OE",  32'(PHY_OE),  0);
                chk("rst_async_MDIO_IN", 32'(MDIO_IN), 0);
                chk("rst_async_ADDR",    32'(ADDR),    0);
                chk("rst_async_WR_DATA", 32'(WR_DATA), 0);
            end
        end
    endtask

    initial begin
        int w0, r0, f0, o0;
        RESET = 1'b0; MDC = 1'b0; MDIO_OE = 1'b0; MDIO_OUT = 1'b0;
        RD_DATA = 16'h1234; chk_en = 1'b0; phase_low = 1'b0;
        set_idle_exp(); m_addr = '0; m_wrd = '0; rx = '0;

        repeat (3) @(negedge CLK);
        #1;
        chk("reset_MDIO_IN",   32'(MDIO_IN),   0);
        chk("reset_PHY_OE",    32'(PHY_OE),    0);
        chk("reset_ADDR",      32'(ADDR),      0);
        chk("reset_WR_DATA",   32'(WR_DATA),   0);
        chk("reset_WR_STB",    32'(WR_STB),    0);
        chk("reset_RD_STB",    32'(RD_STB),    0);
        chk("reset_FRAME_ERR", 32'(FRAME_ERR), 0);
        @(negedge CLK);
        RESET = 1'b1; chk_en = 1'b1;
        drive_idle(2);

        // 1: write ABCD to register 2
        w0 = wr_cnt; r0 = rd_cnt; o0 = oe_cyc;
        drive_frame(2'b01, 2'b01, 5'd1, 5'd2, 16'hABCD, 32, -1);
        drive_idle(2);
        chk("t1_wr_pulses", wr_cnt - w0, 1);
        chk("t1_rd_pulses", rd_cnt - r0, 0);
        chk("t1_addr",      32'(ADDR),    2);
        chk("t1_wr_data",   32'(WR_DATA), 32'hABCD);
        chk("t1_phy_oe",    oe_cyc - o0,  0);

        // 2: read register 4, RD_DATA = 1234
        w0 = wr_cnt; r0 = rd_cnt; o0 = oe_cyc; rx = '0;
        drive_frame(2'b01, 2'b10, 5'd1, 5'd4, 16'h0000, 32, -1);
        drive_idle(2);
        chk("t2_rd_pulses",  rd_cnt - r0, 1);
        chk("t2_wr_pulses",  wr_cnt - w0, 0);
        chk("t2_addr",       32'(ADDR), 4);
        chk("t2_rd_resp",    32'(rx),   32'h01234);
        chk("t2_oe_cycles",  oe_cyc - o0, 34);

        // 3: PHY address mismatch
        w0 = wr_cnt; r0 = rd_cnt; f0 = fe_cnt; o0 = oe_cyc;
        drive_frame(2'b01, 2'b01, 5'd3, 5'd5, 16'h1111, 32, -1);
        drive_idle(1);
        chk("t3_wr_pulses", wr_cnt - w0, 0);
        chk("t3_rd_pulses", rd_cnt - r0, 0);
        chk("t3_ferr",      fe_cnt - f0, 0);
        chk("t3_phy_oe",    oe_cyc - o0, 0);
        chk("t3_addr",      32'(ADDR), 4);

        // 4: bad ST, then bad OP, then a valid write
        w0 = wr_cnt; r0 = rd_cnt; f0 = fe_cnt;
        drive_frame(2'b00, 2'b01, 5'd1, 5'd6, 16'h2222, 32, -1);
        chk("t4_ferr_st", fe_cnt - f0, 1);
        drive_frame(2'b01, 2'b11, 5'd1, 5'd6, 16'h3333, 32, -1);
        chk("t4_ferr_op", fe_cnt - f0, 2);
        chk("t4_no_wr",   wr_cnt - w0, 0);
        chk("t4_no_rd",   rd_cnt - r0, 0);
        drive_frame(2'b01, 2'b01, 5'd1, 5'd7, 16'h5A5A, 32, -1);
        drive_idle(1);
        chk("t4_wr_after", wr_cnt - w0, 1);
        chk("t4_addr",     32'(ADDR),    7);
        chk("t4_wr_data",  32'(WR_DATA), 32'h5A5A);

        // 5: abort a write at bit 20, then reset mid-read, then a clean write
        w0 = wr_cnt;
        drive_frame(2'b01, 2'b01, 5'd1, 5'd9, 16'hFFFF, 20, -1);
        drive_idle(1);
        chk("t5_abort_no_wr", wr_cnt - w0, 0);
        chk("t5_abort_data",  32'(WR_DATA), 32'h5A5A);
        chk("t5_abort_addr",  32'(ADDR),    9);
        drive_frame(2'b01, 2'b10, 5'd1, 5'd4, 16'h0000, 32, 20);
        drive_idle(2);
        w0 = wr_cnt;
        drive_frame(2'b01, 2'b01, 5'd1, 5'd3, 16'h0F0F, 32, -1);
        drive_idle(1);
        chk("t5_wr_after_rst", wr_cnt - w0, 1);
        chk("t5_addr",         32'(ADDR),    3);
        chk("t5_wr_data",      32'(WR_DATA), 32'h0F0F);

        // 6: write immediately followed by a read
        w0 = wr_cnt; r0 = rd_cnt; o0 = oe_cyc; rx = '0;
        drive_frame(2'b01, 2'b01, 5'd1, 5'd5, 16'hC3C3, 32, -1);
        drive_frame(2'b01, 2'b10, 5'd1, 5'd6, 16'h0000, 32, -1);
        drive_idle(2);
        chk("t6_wr_pulses", wr_cnt - w0, 1);
        chk("t6_rd_pulses", rd_cnt - r0, 1);
        chk("t6_wr_data",   32'(WR_DATA), 32'hC3C3);
        chk("t6_addr",      32'(ADDR),    6);
        chk("t6_rd_resp",   32'(rx),      32'h01234);
        chk("t6_oe_cycles", oe_cyc - o0,  34);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
